// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered RV32I/RV64I immediate generator for the decode stage.
// Accepts one instruction per cycle over valid/ready, decodes the immediate format
// from the opcode and presents {instruction, immediate, format, illegal} one cycle
// later. A 2-entry skid buffer keeps o_ready registered under downstream stalls.
// Optional build macro: IMM_EXTEND_ILLEGAL_CNT_EN adds a saturating 16-bit count
// of illegal instructions handed downstream (o_illegalCount).
module imm_extend_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instruction,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instruction,
    output logic [XLEN-1:0] o_immediateExtended,
    output logic [2:0]      o_immFormat,
    output logic            o_illegal
`ifdef IMM_EXTEND_ILLEGAL_CNT_EN
    ,
    output logic [15:0]     o_illegalCount
`endif
);

    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    // Opcodes
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRAN  = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    // Format codes
    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    // Skid FSM states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    localparam entry_t ENTRY_IDLE = '{instr: '0, imm: '0, fmt: FMT_NONE, ill: 1'b0};

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic         valid_q;
    logic         ready_q;
    entry_t       out_q;
    entry_t       skid_q;
    entry_t       dec_entry;

    logic [31:0]  dec_imm32;
    logic         dec_is_shamt;
    logic [2:0]   dec_fmt;
    logic         dec_ill;

    logic         in_xfer;
    logic         out_xfer;
    logic         load_out;
    logic         load_from_skid;
    logic         load_skid;
    logic         clear_out;

    assign in_xfer  = i_valid && ready_q;
    assign out_xfer = valid_q && i_ready;

    // Format decode: 32-bit sign-extended immediate, or a flag for the zero-extended shamt
    always_comb begin
        dec_imm32    = '0;
        dec_is_shamt = 1'b0;
        dec_fmt      = FMT_NONE;
        dec_ill      = 1'b0;
        unique case (i_instruction[6:0])
            OP_LOAD, OP_JALR: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
            end
            OP_IMM: begin
                if (i_instruction[14:12] == 3'b001 || i_instruction[14:12] == 3'b101) begin
                    dec_fmt      = FMT_SHAMT;
                    dec_is_shamt = 1'b1;
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
                end
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
            end
            OP_BRAN: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                             i_instruction[30:25], i_instruction[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {i_instruction[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                             i_instruction[20], i_instruction[30:21], 1'b0};
            end
            OP_REG: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_fmt = FMT_NONE;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Widen to XLEN: shamt is zero-extended, everything else replicates instr[31]
    always_comb begin
        dec_entry       = ENTRY_IDLE;
        dec_entry.instr = i_instruction;
        dec_entry.fmt   = dec_fmt;
        dec_entry.ill   = dec_ill;
        if (dec_is_shamt) begin
            dec_entry.imm = XLEN'(i_instruction[20 +: SHAMT_W]);
        end else begin
            dec_entry.imm = XLEN'($signed(dec_imm32));
        end
    end

    // Skid FSM next-state and register-load controls; flush overrides any transfer
    always_comb begin
        state_d        = state_q;
        load_out       = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        clear_out      = 1'b0;
        if (i_flush) begin
            state_d   = ST_EMPTY;
            clear_out = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d  = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_out = 1'b1;
                    end else if (out_xfer) begin
                        state_d   = ST_EMPTY;
                        clear_out = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d        = ST_ONE;
                        load_out       = 1'b1;
                        load_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    clear_out = 1'b1;
                end
            endcase
        end
    end

    // State register with registered valid/ready derived from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            ready_q <= (state_d != ST_FULL);
        end
    end

    // Output register: idle pattern when empty, otherwise decoded or skid entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q <= ENTRY_IDLE;
        end else if (clear_out) begin
            out_q <= ENTRY_IDLE;
        end else if (load_out) begin
            out_q <= load_from_skid ? skid_q : dec_entry;
        end
    end

    // Skid register captures the entry accepted while the output is stalled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            skid_q <= ENTRY_IDLE;
        end else if (load_skid) begin
            skid_q <= dec_entry;
        end
    end

    assign o_valid             = valid_q;
    assign o_ready             = ready_q;
    assign o_instruction       = out_q.instr;
    assign o_immediateExtended = out_q.imm;
    assign o_immFormat         = out_q.fmt;
    assign o_illegal           = out_q.ill;

`ifdef IMM_EXTEND_ILLEGAL_CNT_EN
    logic [15:0] ill_cnt_q;

    // Saturating count of illegal entries handed downstream; flush does not touch it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ill_cnt_q <= '0;
        end else if (out_xfer && out_q.ill && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_q <= ill_cnt_q + 16'd1;
        end
    end

    assign o_illegalCount = ill_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a queue-based reference model plus a table of known encodings.
module tb_imm_extend_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_instruction;

    logic        r64, v64, ill64;
    logic [31:0] ins64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        r32, v32, ill32;
    logic [31:0] ins32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
`ifdef IMM_EXTEND_ILLEGAL_CNT_EN
    logic [15:0] cnt64, cnt32;
`endif

    imm_extend_pipe #(.XLEN(64)) dut64 (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(r64), .i_instruction(i_instruction), .o_valid(v64), .i_ready(i_ready),
        .o_instruction(ins64), .o_immediateExtended(imm64), .o_immFormat(fmt64),
        .o_illegal(ill64)
`ifdef IMM_EXTEND_ILLEGAL_CNT_EN
        , .o_illegalCount(cnt64)
`endif
    );

    imm_extend_pipe #(.XLEN(32)) dut32 (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(r32), .i_instruction(i_instruction), .o_valid(v32), .i_ready(i_ready),
        .o_instruction(ins32), .o_immediateExtended(imm32), .o_immFormat(fmt32),
        .o_illegal(ill32)
`ifdef IMM_EXTEND_ILLEGAL_CNT_EN
        , .o_illegalCount(cnt32)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t        tbl [14];
    vec_t        q [$];
    int unsigned cnt_model;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: immediate fields pulled out with shifts and masks on integers
    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h67: return 3'd1;
            7'h13:        return (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 3'd6 : 3'd1;
            7'h23:        return 3'd2;
            7'h63:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F:        return 3'd5;
            7'h33:        return 3'd0;
            default:      return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input bit is64);
        longint s, u, r;
        s = longint'($signed(ins));
        u = longint'(ins);
        case (ref_fmt(ins))
            3'd1:    r = s >>> 20;
            3'd2:    r = ((s >>> 25) <<< 5) | ((u >> 7) & 31);
            3'd3:    r = ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11) |
                         (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
            3'd4:    r = s & ~longint'(4095);
            3'd5:    r = ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12) |
                         (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
            3'd6:    r = (u >> 20) & (is64 ? 63 : 31);
            default: r = 0;
        endcase
        if (!is64) r = longint'(r[31:0]);
        return 64'(r);
    endfunction

    function automatic vec_t model(input logic [31:0] ins);
        vec_t e;
        logic [63:0] t;
        e.instr = ins;
        e.fmt   = ref_fmt(ins);
        e.ill   = (e.fmt == 3'd7);
        e.imm64 = ref_imm(ins, 1'b1);
        t       = ref_imm(ins, 1'b0);
        e.imm32 = t[31:0];
        return e;
    endfunction

    task automatic check_outputs();
        chk("valid64", v64, q.size() > 0);
        chk("valid32", v32, q.size() > 0);
        chk("ready64", r64, q.size() < 2);
        chk("ready32", r32, q.size() < 2);
        if (q.size() > 0) begin
            chk("instr64", ins64, q[0].instr);
            chk("instr32", ins32, q[0].instr);
            chk("imm64", imm64, q[0].imm64);
            chk("imm32", imm32, q[0].imm32);
            chk("fmt64", fmt64, q[0].fmt);
            chk("fmt32", fmt32, q[0].fmt);
            chk("ill64", ill64, q[0].ill);
            chk("ill32", ill32, q[0].ill);
        end else begin
            chk("idle_fmt64", fmt64, 3'd7);
            chk("idle_fmt32", fmt32, 3'd7);
        end
`ifdef IMM_EXTEND_ILLEGAL_CNT_EN
        chk("illcnt64", cnt64, cnt_model);
        chk("illcnt32", cnt32, cnt_model);
`endif
    endtask

    // One clock: drive, check at negedge, advance the model at posedge; returns posedge+1
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bit in_x, out_x;
        i_valid       = v;
        i_instruction = ins;
        i_ready       = rdy;
        i_flush       = fl;
        @(negedge i_clk);
        check_outputs();
        in_x  = v && (q.size() < 2);
        out_x = (q.size() > 0) && rdy;
        @(posedge i_clk);
        if (out_x && q[0].ill && cnt_model < 65535) cnt_model++;
        if (out_x) void'(q.pop_front());
        if (fl) q.delete();
        else if (in_x) q.push_back(model(ins));
        #1;
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_instruction = '0;
        #1;
        q.delete();
        cnt_model = 0;
        chk("rst_valid64", v64, 1'b0);
        chk("rst_valid32", v32, 1'b0);
        chk("rst_ready64", r64, 1'b0);
        chk("rst_fmt64", fmt64, 3'd7);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_instr64", ins64, 32'd0);
        chk("rst_ill64", ill64, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_release_ready", r64, 1'b0);
        @(posedge i_clk);
        #1;
        chk("rst_first_edge_ready", r64, 1'b1);
    endtask

    logic [6:0]  ops [10];
    logic [31:0] ins_r;
    logic [31:0] a_ins, b_ins, c_ins;

    initial begin
        tbl[0]  = '{32'hFFC42083, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd1, 1'b0};
        tbl[1]  = '{32'h00112623, 64'h000000000000000C, 32'h0000000C, 3'd2, 1'b0};
        tbl[2]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0};
        tbl[3]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 1'b0};
        tbl[4]  = '{32'h008000EF, 64'h0000000000000008, 32'h00000008, 3'd5, 1'b0};
        tbl[5]  = '{32'h43F0D093, 64'h000000000000003F, 32'h0000001F, 3'd6, 1'b0};
        tbl[6]  = '{32'h002081B3, 64'h0000000000000000, 32'h00000000, 3'd0, 1'b0};
        tbl[7]  = '{32'hFFF08067, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0};
        tbl[8]  = '{32'h12345097, 64'h0000000012345000, 32'h12345000, 3'd4, 1'b0};
        tbl[9]  = '{32'h00309093, 64'h0000000000000003, 32'h00000003, 3'd6, 1'b0};
        tbl[10] = '{32'h0000007F, 64'h0000000000000000, 32'h00000000, 3'd7, 1'b1};
        tbl[11] = '{32'h80000013, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, 3'd1, 1'b0};
        tbl[12] = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd2, 1'b0};
        tbl[13] = '{32'h0000007F, 64'h0000000000000000, 32'h00000000, 3'd7, 1'b1};
        ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F, 7'h7F};

        do_reset();

        // Single LW with one-cycle latency
        cycle(1'b1, 32'hFFC42083, 1'b1, 1'b0);
        chk("lw_valid", v32, 1'b1);
        chk("lw_imm32", imm32, 32'hFFFFFFFC);
        chk("lw_fmt", fmt32, 3'd1);
        chk("lw_ill", ill32, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back table stream, one result per cycle
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, tbl[i].instr, 1'b1, 1'b0);
            chk("tbl_valid", v64, 1'b1);
            chk("tbl_instr", ins64, tbl[i].instr);
            chk("tbl_imm64", imm64, tbl[i].imm64);
            chk("tbl_imm32", {32'd0, imm32}, {32'd0, tbl[i].imm32});
            chk("tbl_fmt", fmt64, tbl[i].fmt);
            chk("tbl_ill", ill64, tbl[i].ill);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: two accepted, third held off until the buffer drains
        a_ins = tbl[1].instr;
        b_ins = tbl[2].instr;
        c_ins = tbl[3].instr;
        cycle(1'b1, a_ins, 1'b0, 1'b0);
        cycle(1'b1, b_ins, 1'b0, 1'b0);
        chk("bp_full_ready", r64, 1'b0);
        chk("bp_hold_instr", ins64, a_ins);
        cycle(1'b1, c_ins, 1'b0, 1'b0);
        chk("bp_still_full", r64, 1'b0);
        chk("bp_still_hold", ins64, a_ins);
        cycle(1'b1, c_ins, 1'b1, 1'b0);
        chk("bp_ready_back", r64, 1'b1);
        chk("bp_second", ins64, b_ins);
        cycle(1'b1, c_ins, 1'b1, 1'b0);
        chk("bp_third", ins64, c_ins);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_drained", v64, 1'b0);

        // Flush in FULL with a simultaneous offer
        cycle(1'b1, a_ins, 1'b0, 1'b0);
        cycle(1'b1, b_ins, 1'b0, 1'b0);
        cycle(1'b1, c_ins, 1'b0, 1'b1);
        chk("flush_valid", v64, 1'b0);
        chk("flush_ready", r64, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while an entry is held
        cycle(1'b1, a_ins, 1'b0, 1'b0);
        chk("pre_rst_valid", v64, 1'b1);
        do_reset();
        cycle(1'b1, tbl[0].instr, 1'b1, 1'b0);
        chk("post_rst_valid", v64, 1'b1);
        chk("post_rst_imm", imm64, tbl[0].imm64);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            int k;
            ins_r = $urandom;
            k = $urandom_range(0, 10);
            if (k < 10) ins_r[6:0] = ops[k];
            cycle($urandom_range(0, 3) != 0, ins_r, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 40) == 0);
        end
        for (int n = 0; n < 3; n++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
